tick_counter_param: RTL and testbench

// Parametrised tick-driven counter with a registered return value.
// - Per-cycle step, up/down direction, wrap or saturate, synchronous load/clear.
// - Registered snapshot port with valid/ready handshake for a consumer.
// - Sits beside tick-style control modules as a shared event/timebase counter.

---
 rtl/tick_counter_param.sv | 144 ++++++++++++++
 tb/tb_tick_counter_param.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_counter_param.sv
// Tick-driven counter with configurable step, direction and wrap/saturate
// behaviour, plus a single-entry snapshot register with a valid/ready
// handshake. A snapshot request dropped while the entry is full sets a
// sticky overrun flag.
module tick_counter_param #(
    parameter int WIDTH    = 8,
    parameter int MAX      = (1 << WIDTH) - 1,
    parameter int STEP     = 1,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_value,
    input  logic             tick_en,
    input  logic             tick_dir,
    output logic [WIDTH-1:0] tick_ret,
    output logic             tick_wrap,
    output logic             tick_sat,
    input  logic             snap_req,
    output logic             snap_valid,
    input  logic             snap_ready,
    output logic [WIDTH-1:0] snap_data,
    output logic             snap_overrun
);

    // Range arithmetic is done one bit wider so that an up-step past MAX
    // and the down-wrap sum cnt+MAX+1 never overflow.
    localparam logic [WIDTH:0]   MAX_X  = (WIDTH+1)'(MAX);
    localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0]   MOD_X  = MAX_X + (WIDTH+1)'(1);
    localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } snap_state_t;

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             sat_q, sat_d;
    snap_state_t      state_q, state_d;
    logic [WIDTH-1:0] snap_data_q, snap_data_d;
    logic             overrun_q, overrun_d;

    logic [WIDTH:0]   cnt_x;
    logic [WIDTH:0]   up_sum;
    logic [WIDTH:0]   up_wrap;
    logic [WIDTH:0]   dn_diff;
    logic [WIDTH:0]   dn_wrap;

    // Next count and event pulses; priority clear > load > tick > hold.
    always_comb begin
        cnt_x   = {1'b0, cnt_q};
        up_sum  = cnt_x + STEP_X;
        up_wrap = up_sum - MOD_X;
        dn_diff = cnt_x - STEP_X;
        dn_wrap = cnt_x + MOD_X - STEP_X;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        sat_d   = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (load_valid) begin
            cnt_d = (load_value > MAX_W) ? MAX_W : load_value;
        end else if (tick_en) begin
            if (!tick_dir) begin
                if (up_sum <= MAX_X) begin
                    cnt_d = up_sum[WIDTH-1:0];
                end else if (SATURATE) begin
                    cnt_d = MAX_W;
                    sat_d = 1'b1;
                end else begin
                    cnt_d  = up_wrap[WIDTH-1:0];
                    wrap_d = 1'b1;
                end
            end else begin
                if (cnt_x >= STEP_X) begin
                    cnt_d = dn_diff[WIDTH-1:0];
                end else if (SATURATE) begin
                    cnt_d = '0;
                    sat_d = 1'b1;
                end else begin
                    cnt_d  = dn_wrap[WIDTH-1:0];
                    wrap_d = 1'b1;
                end
            end
        end
    end

    // Snapshot FSM next state; captures the pre-update count. Clear wins
    // over an overrun set in the same cycle.
    always_comb begin
        state_d     = state_q;
        snap_data_d = snap_data_q;
        overrun_d   = overrun_q;
        case (state_q)
            S_EMPTY: begin
                if (snap_req) begin
                    state_d     = S_FULL;
                    snap_data_d = cnt_q;
                end
            end
            S_FULL: begin
                if (snap_ready) begin
                    if (snap_req) snap_data_d = cnt_q;
                    else          state_d     = S_EMPTY;
                end else if (snap_req) begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = S_EMPTY;
        endcase
        if (clear) overrun_d = 1'b0;
    end

    // State registers, all cleared asynchronously.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            wrap_q      <= 1'b0;
            sat_q       <= 1'b0;
            state_q     <= S_EMPTY;
            snap_data_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            wrap_q      <= wrap_d;
            sat_q       <= sat_d;
            state_q     <= state_d;
            snap_data_q <= snap_data_d;
            overrun_q   <= overrun_d;
        end
    end

    assign tick_ret     = cnt_q;
    assign tick_wrap    = wrap_q;
    assign tick_sat     = sat_q;
    assign snap_valid   = (state_q == S_FULL);
    assign snap_data    = snap_data_q;
    assign snap_overrun = overrun_q;

endmodule

// File: tb/tb_tick_counter_param.sv
// Bench for tick_counter_param: three differently parameterised instances
// share one stimulus stream and are checked every cycle against an
// arithmetic model, plus literal expectations for the key scenarios.
module tb_tick_counter_param;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       clear = 1'b0;
    logic       load_valid = 1'b0;
    logic [8:0] load_value = '0;
    logic       tick_en = 1'b0;
    logic       tick_dir = 1'b0;
    logic       snap_req = 1'b0;
    logic       snap_ready = 1'b0;

    // A: WIDTH=8 MAX=255 STEP=3 wrap; B: WIDTH=4 MAX=9 STEP=4 sat; C: WIDTH=9 MAX=200 STEP=1 wrap
    logic [7:0] a_ret, a_sd;
    logic [3:0] b_ret, b_sd;
    logic [8:0] c_ret, c_sd;
    logic [2:0] o_wrap, o_sat, o_sv, o_ovr;
    logic [8:0] o_ret [3];
    logic [8:0] o_sd  [3];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    tick_counter_param #(.WIDTH(8), .MAX(255), .STEP(3), .SATURATE(1'b0)) dut_a (
        .clock(clock), .reset(reset), .clear(clear), .load_valid(load_valid),
        .load_value(load_value[7:0]), .tick_en(tick_en), .tick_dir(tick_dir),
        .tick_ret(a_ret), .tick_wrap(o_wrap[0]), .tick_sat(o_sat[0]),
        .snap_req(snap_req), .snap_valid(o_sv[0]), .snap_ready(snap_ready),
        .snap_data(a_sd), .snap_overrun(o_ovr[0]));

    tick_counter_param #(.WIDTH(4), .MAX(9), .STEP(4), .SATURATE(1'b1)) dut_b (
        .clock(clock), .reset(reset), .clear(clear), .load_valid(load_valid),
        .load_value(load_value[3:0]), .tick_en(tick_en), .tick_dir(tick_dir),
        .tick_ret(b_ret), .tick_wrap(o_wrap[1]), .tick_sat(o_sat[1]),
        .snap_req(snap_req), .snap_valid(o_sv[1]), .snap_ready(snap_ready),
        .snap_data(b_sd), .snap_overrun(o_ovr[1]));

    tick_counter_param #(.WIDTH(9), .MAX(200), .STEP(1), .SATURATE(1'b0)) dut_c (
        .clock(clock), .reset(reset), .clear(clear), .load_valid(load_valid),
        .load_value(load_value), .tick_en(tick_en), .tick_dir(tick_dir),
        .tick_ret(c_ret), .tick_wrap(o_wrap[2]), .tick_sat(o_sat[2]),
        .snap_req(snap_req), .snap_valid(o_sv[2]), .snap_ready(snap_ready),
        .snap_data(c_sd), .snap_overrun(o_ovr[2]));

    assign o_ret[0] = {1'b0, a_ret};
    assign o_ret[1] = {5'b0, b_ret};
    assign o_ret[2] = c_ret;
    assign o_sd[0]  = {1'b0, a_sd};
    assign o_sd[1]  = {5'b0, b_sd};
    assign o_sd[2]  = c_sd;

    // Model parameters per instance
    int p_w   [3] = '{8, 4, 9};
    int p_max [3] = '{255, 9, 200};
    int p_st  [3] = '{3, 4, 1};
    int p_sat [3] = '{0, 1, 0};

    // Model state
    int m_cnt  [3] = '{0, 0, 0};
    int m_wrap [3] = '{0, 0, 0};
    int m_sat  [3] = '{0, 0, 0};
    int m_full [3] = '{0, 0, 0};
    int m_data [3] = '{0, 0, 0};
    int m_ovr  [3] = '{0, 0, 0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: count semantics as plain integer arithmetic.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                m_cnt[i] = 0; m_wrap[i] = 0; m_sat[i] = 0;
                m_full[i] = 0; m_data[i] = 0; m_ovr[i] = 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                int old, lv, s;
                old = m_cnt[i];
                m_wrap[i] = 0;
                m_sat[i]  = 0;
                if (clear) begin
                    m_cnt[i] = 0;
                end else if (load_valid) begin
                    lv = int'(load_value) % (1 << p_w[i]);
                    m_cnt[i] = (lv > p_max[i]) ? p_max[i] : lv;
                end else if (tick_en) begin
                    s = tick_dir ? old - p_st[i] : old + p_st[i];
                    if (s > p_max[i]) begin
                        if (p_sat[i] != 0) begin m_cnt[i] = p_max[i]; m_sat[i] = 1; end
                        else begin m_cnt[i] = s - (p_max[i] + 1); m_wrap[i] = 1; end
                    end else if (s < 0) begin
                        if (p_sat[i] != 0) begin m_cnt[i] = 0; m_sat[i] = 1; end
                        else begin m_cnt[i] = s + p_max[i] + 1; m_wrap[i] = 1; end
                    end else begin
                        m_cnt[i] = s;
                    end
                end
                if (m_full[i] == 0) begin
                    if (snap_req) begin m_full[i] = 1; m_data[i] = old; end
                end else if (snap_ready) begin
                    if (snap_req) m_data[i] = old;
                    else          m_full[i] = 0;
                end else if (snap_req) begin
                    m_ovr[i] = 1;
                end
                if (clear) m_ovr[i] = 0;
            end
        end
    end

    // Cycle-by-cycle comparison against the model, on the falling edge.
    always @(negedge clock) begin
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("ret[%0d]", i),  32'(o_ret[i]),  32'(m_cnt[i]));
            chk($sformatf("wrap[%0d]", i), 32'(o_wrap[i]), 32'(m_wrap[i]));
            chk($sformatf("sat[%0d]", i),  32'(o_sat[i]),  32'(m_sat[i]));
            chk($sformatf("sv[%0d]", i),   32'(o_sv[i]),   32'(m_full[i]));
            chk($sformatf("sd[%0d]", i),   32'(o_sd[i]),   32'(m_data[i]));
            chk($sformatf("ovr[%0d]", i),  32'(o_ovr[i]),  32'(m_ovr[i]));
        end
    end

    // Apply one cycle of inputs; returns 1 time unit after the capturing edge.
    task automatic step(input logic clr, input logic ld, input int lv, input logic en,
                        input logic dir, input logic req, input logic rdy);
        clear = clr; load_valid = ld; load_value = 9'(lv);
        tick_en = en; tick_dir = dir; snap_req = req; snap_ready = rdy;
        @(posedge clock);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        chk("reset_ret_a", 32'(a_ret), 0);
        chk("reset_sv_c", 32'(o_sv[2]), 0);
        chk("reset_ovr_c", 32'(o_ovr[2]), 0);
        reset = 1'b0;

        // Load 254 then tick up: A wraps to 1, B saturates, C wraps to 0
        step(0, 1, 254, 0, 0, 0, 0);
        chk("load_a", 32'(a_ret), 254);
        chk("load_clamp_c", 32'(c_ret), 200);
        step(0, 0, 0, 1, 0, 0, 0);
        chk("wrap_up_a", 32'(a_ret), 1);
        chk("wrap_up_a_pulse", 32'(o_wrap[0]), 1);
        chk("wrap_up_c", 32'(c_ret), 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("wrap_a_deassert", 32'(o_wrap[0]), 0);

        // Saturating instance B: 8 up -> 9, 2 down -> 0, 0 down -> 0
        step(0, 1, 8, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        chk("sat_up_b", 32'(b_ret), 9);
        chk("sat_up_b_pulse", 32'(o_sat[1]), 1);
        chk("sat_up_b_nowrap", 32'(o_wrap[1]), 0);
        step(0, 1, 2, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 0, 0);
        chk("sat_dn_b", 32'(b_ret), 0);
        chk("sat_dn_b_pulse", 32'(o_sat[1]), 1);
        step(0, 0, 0, 1, 1, 0, 0);
        chk("sat_dn_b_again", 32'(o_sat[1]), 1);

        // Priority: clear beats load and tick; then load clamps
        step(1, 1, 7, 1, 0, 0, 0);
        chk("clr_prio_a", 32'(a_ret), 0);
        chk("clr_prio_c", 32'(c_ret), 0);
        step(0, 1, 300, 0, 0, 0, 0);
        chk("load300_c", 32'(c_ret), 200);
        chk("load300_a", 32'(a_ret), 44);

        // Snapshot at 12, hold through ticks, overrun at 15, then accept
        step(0, 1, 12, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        chk("snap_v_c", 32'(o_sv[2]), 1);
        chk("snap_d_c", 32'(c_sd), 12);
        repeat (3) step(0, 0, 0, 1, 0, 0, 0);
        chk("ret15_c", 32'(c_ret), 15);
        step(0, 0, 0, 0, 0, 1, 0);
        chk("ovr_d_c", 32'(c_sd), 12);
        chk("ovr_c", 32'(o_ovr[2]), 1);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("accept_v_c", 32'(o_sv[2]), 0);
        chk("ovr_sticky_c", 32'(o_ovr[2]), 1);

        // Back-to-back capture at 40
        step(0, 1, 39, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 1);
        chk("b2b_v_c", 32'(o_sv[2]), 1);
        chk("b2b_d_c", 32'(c_sd), 40);

        // Clear + request: captures pre-clear count, overrun cleared
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1, 0);
        chk("clrreq_ret_c", 32'(c_ret), 0);
        chk("clrreq_d_c", 32'(c_sd), 41);
        chk("clrreq_ovr_c", 32'(o_ovr[2]), 0);

        // Reset mid-operation with count 5 and a pending snapshot
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 1, 5, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        chk("pre_rst_ret_c", 32'(c_ret), 5);
        chk("pre_rst_v_c", 32'(o_sv[2]), 1);
        #3 reset = 1'b1;
        #1;
        chk("async_rst_ret_c", 32'(c_ret), 0);
        chk("async_rst_v_c", 32'(o_sv[2]), 0);
        chk("async_rst_d_c", 32'(c_sd), 0);
        @(posedge clock);
        #1;
        chk("rst_hold_ret_a", 32'(a_ret), 0);
        reset = 1'b0;

        // Mixed traffic checked by the model every cycle
        for (int k = 0; k < 300; k++) begin
            step(($urandom_range(15) == 0), ($urandom_range(7) == 0),
                 int'($urandom_range(511)), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom));
        end
        step(0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
